move_sched: RTL

MOVE_SCHED -- requirements
Module: move_sched

---
 rtl/move_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/move_sched.sv
// Move scheduler: round-robin A/B command intake, FIFO queue, motion-engine dispatch.
// Optional MOVE_SCHED_STATS_EN adds a completed-move counter output (moves_cnt).
module move_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [CW-1:0] a_incr,
    input  logic          a_dir,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [CW-1:0] b_incr,
    input  logic          b_dir,
    input  logic          halt,
    output logic          mv_start,
    output logic [CW-1:0] mv_incr,
    output logic          mv_dir,
    input  logic          mv_done,
    output logic          mv_abort,
    output logic          buffer_dtr,
`ifdef MOVE_SCHED_STATS_EN
    output logic [15:0]   moves_cnt,
`endif
    output logic          move_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW:0]   mem_q [DEPTH];
    logic [CW:0]   head;
    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] incr_q, incr_d;
    logic          dir_q, dir_d;
    logic          start_q, start_d;
    logic          abort_q, abort_d;
    logic          full, empty, gnt_b, can_push;
    logic          push_a, push_b, push, pop;

    assign full  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign empty = (wptr_q == rptr_q);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // rr_q set means B holds priority for the next contested cycle
    assign gnt_b    = b_valid && (!a_valid || rr_q);
    assign can_push = !full && !halt && wb_rst_ni;
    assign a_ready  = can_push && !gnt_b;
    assign b_ready  = can_push && gnt_b;
    assign push_a   = a_valid && a_ready;
    assign push_b   = b_valid && b_ready;
    assign push     = push_a || push_b;
    assign pop      = (state_q == S_LOAD) && !halt && !empty;

    assign buffer_dtr = !full;
    assign move_done  = empty && (state_q == S_IDLE);
    assign mv_start   = start_q;
    assign mv_abort   = abort_q;
    assign mv_incr    = incr_q;
    assign mv_dir     = dir_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + (AW+1)'(1) : rptr_q;
        rr_d    = push ? push_a : rr_q;
        incr_d  = incr_q;
        dir_d   = dir_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !halt) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (halt || empty) begin
                    state_d = S_IDLE;
                end else begin
                    incr_d = head[CW-1:0];
                    dir_d  = head[CW];
                    // zero-count moves are retired without engaging the engine
                    if (head[CW-1:0] == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                        start_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (mv_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (halt) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            incr_q  <= '0;
            dir_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            state_q <= state_d;
            rr_q    <= rr_d;
            incr_q  <= incr_d;
            dir_q   <= dir_d;
            start_q <= start_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= push_a ? {a_dir, a_incr} : {b_dir, b_incr};
        end
    end

`ifdef MOVE_SCHED_STATS_EN
    logic        fin_ev;
    logic [15:0] cnt_q;

    assign fin_ev = (pop && head[CW-1:0] == '0) ||
                    ((state_q == S_RUN) && mv_done && !halt);
    assign moves_cnt = cnt_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
        end else if (fin_ev) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`endif

endmodule
